div_ctrl: RTL
=============

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width.
REQ-002 clk  input  1  core clock; all state on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 es_valid  input  1  EX-stage instruction valid.
REQ-005 es_div_op  input  1  EX instruction is DIV/DIVU.
REQ-006 es_div_signed  input  1  1 = DIV (signed), 0 = DIVU.
REQ-007 es_src1  input  DATA_W  dividend (already forwarded).
REQ-008 es_src2  input  DATA_W  divisor (already forwarded).
REQ-009 flush  input  1  exception/eret flush; kills the in-flight divide.
REQ-010 ms_allowin  input  1  MEM stage can accept the EX instruction.
REQ-011 div_stop  output  1  hold EX, feeds the hazard unit's EX stall.
REQ-012 hilo_we  output  1  one-cycle HI/LO write strobe.
REQ-013 hi_wdata  output  DATA_W  remainder.
REQ-014 lo_wdata  output  DATA_W  quotient.
REQ-015 busy  output  1  state != IDLE.

Function
REQ-016 FSM states IDLE, BUSY, DONE; one-hot or binary encoding is free.
REQ-017 IDLE->BUSY when es_valid & es_div_op & !flush; operands, sign flag and absolute values are latched in that cycle T.
REQ-018 BUSY performs one restoring step per cycle (DATA_W steps); 6-bit counter 0..DATA_W-1; BUSY->DONE after step DATA_W-1 (cycle T+DATA_W, so DONE at T+DATA_W+1).
REQ-019 div_stop = es_valid & es_div_op & (state != DONE) & !flush; combinational; high for cycles T..T+DATA_W, low in DONE.
REQ-020 DONE: hilo_we = ms_allowin; DONE->IDLE when ms_allowin; DONE holds, results stable, while ms_allowin = 0.
REQ-021 Signed: quotient negated when operand signs differ; remainder takes the dividend's sign; 0x80000000 / 0xFFFFFFFF gives q = 0x80000000, r = 0 (two's-complement wrap, no trap).
REQ-022 Divide by zero: q = all ones, r = dividend, for both signed and unsigned.
REQ-023 flush in any state: next state IDLE, counter cleared, hilo_we = 0 that cycle; a divide present in EX together with flush is not started.
REQ-024 hi_wdata/lo_wdata change only on the BUSY->DONE edge; they are undefined for consumers when hilo_we = 0.
REQ-025 A new divide in EX in the cycle after DONE->IDLE starts normally (back-to-back, no bubble beyond the IDLE cycle).

Reset
REQ-026 resetn low: state IDLE, counter 0, div_stop 0, hilo_we 0, busy 0, hi_wdata/lo_wdata 0; takes effect immediately, including mid-BUSY.
REQ-027 First divide is accepted on the first rising edge after resetn deasserts.

Configuration
REQ-028 Macro DIV_ZERO_FAST_EN defined: a zero divisor in IDLE goes directly to DONE at T+1 with REQ-022 results; div_stop high only in cycle T.
REQ-029 DIV_ZERO_FAST_EN undefined: a zero divisor takes the full DATA_W-cycle BUSY path; results are identical to REQ-022.

Structure
REQ-030 Package div_pkg holds the state encoding, DIV_ITERS (= DATA_W) and the counter width.
REQ-031 Sub-module div_core holds the remainder/quotient shift registers and the per-step subtract; div_ctrl owns the FSM, the sign handling and the stall/strobe logic.

Verification
REQ-032 DIVU 100/7 issued at T: div_stop high for 33 cycles, DONE at T+33, hilo_we = 1, lo = 14, hi = 2.
REQ-033 DIV -7/2: lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIV 7/-2: lo = 0xFFFFFFFD, hi = 1.
REQ-034 DIVU 5/0: with DIV_ZERO_FAST_EN, DONE at T+1 with lo = 0xFFFFFFFF, hi = 5; without it, DONE at T+33 with the same values.
REQ-035 flush asserted at BUSY step 10: IDLE next cycle, no hilo_we; a following DIVU 9/3 yields lo = 3, hi = 0.
REQ-036 ms_allowin = 0 for 4 cycles in DONE: state held, div_stop low, hilo_we rises only when ms_allowin = 1, then IDLE.
REQ-037 resetn pulsed low at BUSY step 20: all outputs 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the iterative divider controller.
//   DIV_ITERS : restoring steps per divide (equals the default operand width)
//   CNT_W     : width of the step counter
//   div_state_t : controller state encoding
package div_pkg;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_core.sv
// div_core -- unsigned restoring divide datapath, one quotient bit per step.
// Ports:
//   clk, resetn        : core clock, async active-low reset
//   load               : capture dividend/divisor magnitudes, clear remainder
//   step               : advance one restoring step
//   dividend, divisor  : unsigned magnitudes presented with load
//   quo_nxt, rem_nxt   : quotient/remainder after the step in progress, so the
//                        controller can capture final results on the last step
module div_core
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_ITERS
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quo_nxt,
  output logic [DATA_W-1:0] rem_nxt
);

  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dvsr;
  logic [DATA_W:0]   partial;
  logic [DATA_W:0]   diff;

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // remainder while quotient bits enter at the LSB.
  always_comb begin
    partial = {rem, quo[DATA_W-1]};
    diff    = partial - {1'b0, dvsr};
    if (!diff[DATA_W]) begin
      rem_nxt = diff[DATA_W-1:0];
      quo_nxt = {quo[DATA_W-2:0], 1'b1};
    end else begin
      rem_nxt = partial[DATA_W-1:0];
      quo_nxt = {quo[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quo  <= '0;
      rem  <= '0;
      dvsr <= '0;
    end else if (load) begin
      quo  <= dividend;
      rem  <= '0;
      dvsr <= divisor;
    end else if (step) begin
      quo  <= quo_nxt;
      rem  <= rem_nxt;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl -- EX-stage DIV/DIVU controller: stalls EX while an iterative
// divide runs, then strobes the HI/LO write when MEM accepts the instruction.
// Ports:
//   clk, resetn             : core clock, async active-low reset
//   es_valid, es_div_op     : EX instruction valid / is a divide
//   es_div_signed           : 1 = DIV, 0 = DIVU
//   es_src1, es_src2        : dividend, divisor
//   flush                   : kill any in-flight divide
//   ms_allowin              : MEM can accept the EX instruction
//   div_stop                : EX stall request (combinational)
//   hilo_we                 : one-cycle HI/LO write strobe
//   hi_wdata, lo_wdata      : remainder, quotient
//   busy                    : controller not idle
// Build option: DIV_ZERO_FAST_EN -- when defined, a zero divisor skips the
// iterative path and completes in one cycle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for a divide in EX
// ST_BUSY | one restoring step per cycle, counter 0..DATA_W-1
// ST_DONE | results valid; write HI/LO once MEM accepts
module div_ctrl
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_ITERS
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              es_valid,
  input  logic              es_div_op,
  input  logic              es_div_signed,
  input  logic [DATA_W-1:0] es_src1,
  input  logic [DATA_W-1:0] es_src2,
  input  logic              flush,
  input  logic              ms_allowin,
  output logic              div_stop,
  output logic              hilo_we,
  output logic [DATA_W-1:0] hi_wdata,
  output logic [DATA_W-1:0] lo_wdata,
  output logic              busy
);

  div_state_t        state;
  div_state_t        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              start;
  logic              last_step;
  logic              src2_zero;
  logic              fast_zero;
  logic              q_neg;
  logic              r_neg;
  logic              dvsr_zero;
  logic [DATA_W-1:0] dividend_raw;
  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;
  logic [DATA_W-1:0] quo_nxt;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] q_fin;
  logic [DATA_W-1:0] r_fin;

  assign start     = (state == ST_IDLE) & es_valid & es_div_op & !flush;
  assign last_step = (cnt == CNT_W'(DATA_W - 1));
  assign src2_zero = (es_src2 == '0);
  assign abs1      = (es_div_signed & es_src1[DATA_W-1]) ? -es_src1 : es_src1;
  assign abs2      = (es_div_signed & es_src2[DATA_W-1]) ? -es_src2 : es_src2;

`ifdef DIV_ZERO_FAST_EN
  assign fast_zero = src2_zero;
`else
  assign fast_zero = 1'b0;
`endif

  // resetn gates the stall so it reads 0 while reset is held, even with a
  // divide sitting in EX.
  assign div_stop = resetn & es_valid & es_div_op & (state != ST_DONE) & !flush;
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    hilo_we   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = fast_zero ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        if (flush)          state_nxt = ST_IDLE;
        else if (last_step) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (ms_allowin) begin
          hilo_we   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                           cnt <= '0;
    else if (state == ST_BUSY && !flush)   cnt <= last_step ? '0 : cnt + 1'b1;
    else                                   cnt <= '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      dvsr_zero    <= 1'b0;
      dividend_raw <= '0;
    end else if (start) begin
      q_neg        <= es_div_signed & (es_src1[DATA_W-1] ^ es_src2[DATA_W-1]);
      r_neg        <= es_div_signed & es_src1[DATA_W-1];
      dvsr_zero    <= src2_zero;
      dividend_raw <= es_src1;
    end
  end

  div_core #(.DATA_W(DATA_W)) u_core (
    .clk      (clk),
    .resetn   (resetn),
    .load     (start),
    .step     (state == ST_BUSY),
    .dividend (abs1),
    .divisor  (abs2),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

  // Divide-by-zero bypasses the sign fix-up: the raw dividend is the
  // remainder and the quotient is all ones regardless of signedness.
  always_comb begin
    q_fin = dvsr_zero ? '1 : (q_neg ? -quo_nxt : quo_nxt);
    r_fin = dvsr_zero ? dividend_raw : (r_neg ? -rem_nxt : rem_nxt);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_wdata <= '0;
      lo_wdata <= '0;
    end else if (state == ST_BUSY && !flush && last_step) begin
      hi_wdata <= r_fin;
      lo_wdata <= q_fin;
    end else if (start && fast_zero) begin
      hi_wdata <= es_src1;
      lo_wdata <= '1;
    end
  end

endmodule
